// File: rtl/gol_seq_ctrl.sv
// Game-of-life generation sequencer: serial seed load, G-generation stepping, serial board readout.
// Define GOL_SEQ_STABLE_STOP_EN to end a run early once the board stops changing.
module gol_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned GEN_W  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_start,
    input  logic [GEN_W-1:0]          i_gen_count,
    input  logic                      i_seed_valid,
    input  logic                      i_seed_bit,
    output logic                      o_seed_ready,
    output logic [WIDTH*HEIGHT-1:0]   o_seed,
    output logic                      o_load,
    output logic                      o_step,
    input  logic [WIDTH*HEIGHT-1:0]   i_board,
    output logic                      o_out_valid,
    output logic                      o_out_bit,
    input  logic                      i_out_ready,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [GEN_W-1:0]          o_gen,
    output logic                      o_stable
);
    localparam int unsigned N     = WIDTH * HEIGHT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StPrime, StStep, StSettle, StDump
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GEN_W-1:0] count_q, count_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [GEN_W-1:0] gen_inc;
    logic [N-1:0]     seed_q, seed_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [N-1:0]     out_word;
    logic             first_q, first_d;
    logic             done_q, done_d;
    logic             stable_q, stable_d;
    logic             stop_stable;

`ifdef GOL_SEQ_STABLE_STOP_EN
    logic [N-1:0] snap_q;

    assign stop_stable = (i_board == snap_q);

    // Snapshot holds the previous generation so SETTLE can tell whether the last step changed anything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            snap_q <= '0;
        end else if (state_q == StPrime) begin
            snap_q <= seed_q;
        end else if (state_q == StSettle) begin
            snap_q <= i_board;
        end
    end
`else
    assign stop_stable = 1'b0;
`endif

    assign gen_inc = gen_q + 1'b1;
    // The board is only valid one cycle after the last load/step, so capture happens in DUMP itself.
    assign out_word = first_q ? i_board : shift_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        count_d  = count_q;
        gen_d    = gen_q;
        seed_d   = seed_q;
        shift_d  = shift_q;
        stable_d = stable_q;
        first_d  = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    count_d  = i_gen_count;
                    gen_d    = '0;
                    stable_d = 1'b0;
                    idx_d    = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                if (i_seed_valid) begin
                    seed_d[idx_q] = i_seed_bit;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = StPrime;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StPrime: begin
                if (count_q != '0) begin
                    state_d = StStep;
                end else begin
                    first_d = 1'b1;
                    state_d = StDump;
                end
            end
            StStep: begin
                state_d = StSettle;
            end
            StSettle: begin
                gen_d = (&gen_q) ? gen_q : gen_inc;
                if (stop_stable) begin
                    stable_d = 1'b1;
                    first_d  = 1'b1;
                    state_d  = StDump;
                end else if (gen_inc == count_q) begin
                    first_d = 1'b1;
                    state_d = StDump;
                end else begin
                    state_d = StStep;
                end
            end
            StDump: begin
                shift_d = out_word;
                if (i_out_ready) begin
                    shift_d = out_word >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            count_q  <= '0;
            gen_q    <= '0;
            seed_q   <= '0;
            shift_q  <= '0;
            first_q  <= 1'b0;
            done_q   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            gen_q    <= gen_d;
            seed_q   <= seed_d;
            shift_q  <= shift_d;
            first_q  <= first_d;
            done_q   <= done_d;
            stable_q <= stable_d;
        end
    end

    // Array-facing strobes fall in the same cycle reset is raised.
    assign o_load       = (state_q == StPrime) && !i_reset;
    assign o_step       = (state_q == StStep) && !i_reset;
    assign o_out_valid  = (state_q == StDump) && !i_reset;
    assign o_out_bit    = (state_q == StDump) && out_word[0];
    assign o_seed_ready = (state_q == StLoad);
    assign o_seed       = seed_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = done_q;
    assign o_gen        = gen_q;
    assign o_stable     = stable_q;

endmodule

// File: tb/tb_gol_seq_ctrl.sv
// Bench for gol_seq_ctrl on a 4x4 board with a behavioural life array and reference run model.
module tb_gol_seq_ctrl;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [GW-1:0] i_gen_count = '0;
    logic          i_seed_valid = 1'b0;
    logic          i_seed_bit = 1'b0;
    logic          o_seed_ready;
    logic [N-1:0]  o_seed;
    logic          o_load;
    logic          o_step;
    logic [N-1:0]  board = '0;
    logic          o_out_valid;
    logic          o_out_bit;
    logic          i_out_ready = 1'b0;
    logic          o_busy;
    logic          o_done;
    logic [GW-1:0] o_gen;
    logic          o_stable;

    int vecs = 0;
    int errs = 0;
    int cyc_cnt = 0;
    int load_cnt = 0;
    int step_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    int load_at = 0;
    int step_at = 0;

    gol_seq_ctrl #(.WIDTH(W), .HEIGHT(H), .GEN_W(GW)) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_start     (i_start),
        .i_gen_count (i_gen_count),
        .i_seed_valid(i_seed_valid),
        .i_seed_bit  (i_seed_bit),
        .o_seed_ready(o_seed_ready),
        .o_seed      (o_seed),
        .o_load      (o_load),
        .o_step      (o_step),
        .i_board     (board),
        .o_out_valid (o_out_valid),
        .o_out_bit   (o_out_bit),
        .i_out_ready (i_out_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_gen       (o_gen),
        .o_stable    (o_stable)
    );

    initial forever #5 clk = ~clk;

    // Conway's rule on a 4x4 board, cells beyond the edge are dead.
    function automatic logic [N-1:0] life(input logic [N-1:0] b);
        logic [N-1:0] nb;
        int n;
        nb = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H &&
                            c + dc >= 0 && c + dc < W) begin
                            n += int'(b[(r + dr) * W + c + dc]);
                        end
                    end
                end
                nb[r * W + c] = (n == 3) || (b[r * W + c] && n == 2);
            end
        end
        return nb;
    endfunction

    function automatic void ref_run(input logic [N-1:0] seed, input int gen,
                                    output logic [N-1:0] fin, output int g, output bit st);
        logic [N-1:0] b, nb;
        b = seed;
        g = 0;
        st = 1'b0;
        for (int k = 0; k < gen; k++) begin
            nb = life(b);
            g++;
`ifdef GOL_SEQ_STABLE_STOP_EN
            if (nb == b) begin
                st = 1'b1;
                break;
            end
`endif
            b = nb;
        end
        fin = b;
    endfunction

    // Cell array model plus event bookkeeping.
    always @(posedge clk) begin
        if (o_load) begin
            board <= o_seed;
            load_cnt <= load_cnt + 1;
            load_at <= cyc_cnt;
        end else if (o_step) begin
            board <= life(board);
        end
        if (o_step) begin
            step_cnt <= step_cnt + 1;
            step_at <= cyc_cnt;
        end
        if (o_load && o_step) overlap_cnt <= overlap_cnt + 1;
        if (o_done) done_cnt <= done_cnt + 1;
        cyc_cnt <= cyc_cnt + 1;
    end

    // gap < 0 picks a random 0..2 cycle gap before each seed beat.
    task automatic do_run(input logic [N-1:0] seed, input int gen, input int rmode, input int gap,
                          output logic [N-1:0] rd, output int loads, output int steps,
                          output bit done_seen, output int first_valid, output int unstable,
                          output int last_seed_cyc);
        int l0, s0, cyc, idx, g;
        logic prev_bit, rdy;
        bit stalled;
        l0 = load_cnt;
        s0 = step_cnt;
        rd = '0;
        unstable = 0;
        first_valid = -1;
        stalled = 1'b0;
        prev_bit = 1'b0;
        last_seed_cyc = 0;
        i_start = 1'b1;
        i_gen_count = GW'(gen);
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            i_seed_valid = 1'b0;
            repeat (g) @(negedge clk);
            i_seed_valid = 1'b1;
            i_seed_bit = seed[i];
            last_seed_cyc = cyc_cnt;
            @(negedge clk);
        end
        i_seed_valid = 1'b0;
        cyc = 0;
        idx = 0;
        while (idx < N && cyc < 1000) begin
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            i_out_ready = rdy;
            if (o_out_valid) begin
                if (first_valid < 0) first_valid = cyc_cnt;
                if (stalled && o_out_bit !== prev_bit) unstable++;
                if (rdy) begin
                    rd[idx] = o_out_bit;
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev_bit = o_out_bit;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_out_ready = 1'b0;
        done_seen = o_done;
        loads = load_cnt - l0;
        steps = step_cnt - s0;
        vecs++;
        if (idx < N) begin
            errs++;
            $display("FAIL readout_timeout: got %0d beats, required %0d", idx, N);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        #1;
        vecs += 9;
        if (o_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        if (o_load !== 1'b0) begin errs++; $display("FAIL reset_load: got %b want 0", o_load); end
        if (o_step !== 1'b0) begin errs++; $display("FAIL reset_step: got %b want 0", o_step); end
        if (o_out_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", o_out_valid); end
        if (o_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", o_done); end
        if (o_gen !== '0) begin errs++; $display("FAIL reset_gen: got %0d want 0", o_gen); end
        if (o_stable !== 1'b0) begin errs++; $display("FAIL reset_stable: got %b want 0", o_stable); end
        if (o_seed !== '0) begin errs++; $display("FAIL reset_seed: got %h want 0", o_seed); end
        if (o_seed_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", o_seed_ready); end
        @(negedge clk);
    endtask

    task automatic test_blinker;
        logic [N-1:0] rd;
        int loads, steps, fv, un, ls;
        bit dn;
        do_run(16'h0070, 1, 0, 0, rd, loads, steps, dn, fv, un, ls);
        vecs += 8;
        if (rd !== 16'h0222) begin errs++; $display("FAIL blinker_board: got %h want 0222", rd); end
        if (o_gen !== 16'd1) begin errs++; $display("FAIL blinker_gen: got %0d want 1", o_gen); end
        if (loads != 1) begin errs++; $display("FAIL blinker_loads: got %0d want 1", loads); end
        if (steps != 1) begin errs++; $display("FAIL blinker_steps: got %0d want 1", steps); end
        if (dn !== 1'b1) begin errs++; $display("FAIL blinker_done: got %b want 1", dn); end
        if (load_at != ls + 1) begin errs++; $display("FAIL blinker_load_time: got %0d want %0d", load_at, ls + 1); end
        if (step_at != ls + 2) begin errs++; $display("FAIL blinker_step_time: got %0d want %0d", step_at, ls + 2); end
        if (fv != step_at + 2) begin errs++; $display("FAIL blinker_valid_time: got %0d want %0d", fv, step_at + 2); end
        @(negedge clk);
        vecs++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            errs++; $display("FAIL blinker_after: got done=%b busy=%b want 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_blinker_two;
        logic [N-1:0] rd;
        int loads, steps, fv, un, ls;
        bit dn;
        do_run(16'h0070, 2, 0, 0, rd, loads, steps, dn, fv, un, ls);
        vecs += 3;
        if (rd !== 16'h0070) begin errs++; $display("FAIL blinker2_board: got %h want 0070", rd); end
        if (o_gen !== 16'd2) begin errs++; $display("FAIL blinker2_gen: got %0d want 2", o_gen); end
        if (o_stable !== 1'b0) begin errs++; $display("FAIL blinker2_stable: got %b want 0", o_stable); end
    endtask

    task automatic test_block;
        logic [N-1:0] rd;
        int loads, steps, fv, un, ls, eg;
        bit dn, es;
`ifdef GOL_SEQ_STABLE_STOP_EN
        eg = 1; es = 1'b1;
`else
        eg = 10; es = 1'b0;
`endif
        do_run(16'h0660, 10, 0, 0, rd, loads, steps, dn, fv, un, ls);
        vecs += 4;
        if (rd !== 16'h0660) begin errs++; $display("FAIL block_board: got %h want 0660", rd); end
        if (o_gen !== GW'(eg)) begin errs++; $display("FAIL block_gen: got %0d want %0d", o_gen, eg); end
        if (o_stable !== es) begin errs++; $display("FAIL block_stable: got %b want %b", o_stable, es); end
        if (steps != eg) begin errs++; $display("FAIL block_steps: got %0d want %0d", steps, eg); end
    endtask

    task automatic test_zero_gen;
        logic [N-1:0] rd;
        int loads, steps, fv, un, ls;
        bit dn;
        do_run(16'h0070, 0, 0, 0, rd, loads, steps, dn, fv, un, ls);
        vecs += 5;
        if (rd !== 16'h0070) begin errs++; $display("FAIL zero_board: got %h want 0070", rd); end
        if (steps != 0) begin errs++; $display("FAIL zero_steps: got %0d want 0", steps); end
        if (o_gen !== '0) begin errs++; $display("FAIL zero_gen: got %0d want 0", o_gen); end
        if (fv != load_at + 1) begin errs++; $display("FAIL zero_valid_time: got %0d want %0d", fv, load_at + 1); end
        if (dn !== 1'b1) begin errs++; $display("FAIL zero_done: got %b want 1", dn); end
    endtask

    task automatic test_backpressure;
        logic [N-1:0] seed, rd_a, rd_b, exp_b;
        int loads, steps, fv, un, ls, eg;
        bit dn, es;
        seed = 16'($urandom);
        ref_run(seed, 3, exp_b, eg, es);
        do_run(seed, 3, 1, 0, rd_a, loads, steps, dn, fv, un, ls);
        vecs += 3;
        if (rd_a !== exp_b) begin errs++; $display("FAIL bp_board: got %h want %h", rd_a, exp_b); end
        if (un != 0) begin errs++; $display("FAIL bp_hold: got %0d changes while stalled want 0", un); end
        if (dn !== 1'b1) begin errs++; $display("FAIL bp_done: got %b want 1", dn); end
        do_run(seed, 3, 0, 3, rd_b, loads, steps, dn, fv, un, ls);
        vecs += 2;
        if (rd_b !== exp_b) begin errs++; $display("FAIL gap_board: got %h want %h", rd_b, exp_b); end
        if (o_gen !== GW'(eg)) begin errs++; $display("FAIL gap_gen: got %0d want %0d", o_gen, eg); end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] rd;
        int loads, steps, fv, un, ls, cyc, d0;
        bit dn;
        i_start = 1'b1;
        i_gen_count = GW'(5);
        @(negedge clk);
        i_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            i_seed_valid = 1'b1;
            i_seed_bit = (i >= 4 && i <= 6);
            @(negedge clk);
        end
        i_seed_valid = 1'b0;
        cyc = 0;
        while (o_gen !== GW'(2) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        vecs++;
        if (o_step !== 1'b1) begin errs++; $display("FAIL mid_pre_step: got %b want 1", o_step); end
        d0 = done_cnt;
        i_reset = 1'b1;
        #1;
        vecs++;
        if (o_step !== 1'b0) begin errs++; $display("FAIL mid_step_drop: got %b want 0", o_step); end
        @(negedge clk);
        i_reset = 1'b0;
        vecs += 2;
        if (o_busy !== 1'b0) begin errs++; $display("FAIL mid_busy: got %b want 0", o_busy); end
        if (o_gen !== '0) begin errs++; $display("FAIL mid_gen: got %0d want 0", o_gen); end
        repeat (5) @(negedge clk);
        vecs++;
        if (done_cnt != d0) begin errs++; $display("FAIL mid_no_done: got %0d pulses want 0", done_cnt - d0); end
        do_run(16'h0070, 1, 0, 0, rd, loads, steps, dn, fv, un, ls);
        vecs += 2;
        if (rd !== 16'h0222) begin errs++; $display("FAIL mid_rerun_board: got %h want 0222", rd); end
        if (dn !== 1'b1) begin errs++; $display("FAIL mid_rerun_done: got %b want 1", dn); end
    endtask

    task automatic test_random;
        logic [N-1:0] seed, rd, exp_b;
        int loads, steps, fv, un, ls, gen, eg;
        bit dn, es;
        for (int t = 0; t < 10; t++) begin
            seed = 16'($urandom);
            gen = int'($urandom_range(0, 6));
            ref_run(seed, gen, exp_b, eg, es);
            do_run(seed, gen, 2, -1, rd, loads, steps, dn, fv, un, ls);
            vecs += 6;
            if (rd !== exp_b) begin errs++; $display("FAIL rand_board[%0d]: got %h want %h", t, rd, exp_b); end
            if (o_gen !== GW'(eg)) begin errs++; $display("FAIL rand_gen[%0d]: got %0d want %0d", t, o_gen, eg); end
            if (o_stable !== es) begin errs++; $display("FAIL rand_stable[%0d]: got %b want %b", t, o_stable, es); end
            if (steps != eg) begin errs++; $display("FAIL rand_steps[%0d]: got %0d want %0d", t, steps, eg); end
            if (loads != 1) begin errs++; $display("FAIL rand_loads[%0d]: got %0d want 1", t, loads); end
            if (un != 0) begin errs++; $display("FAIL rand_hold[%0d]: got %0d want 0", t, un); end
        end
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_blinker_two();
        test_block();
        test_zero_gen();
        test_backpressure();
        test_reset_mid();
        test_random();
        vecs++;
        if (overlap_cnt != 0) begin
            errs++; $display("FAIL load_step_overlap: got %0d cycles want 0", overlap_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
